// File: rtl/tcp_rr_arbiter_if.sv
// Request/grant bundle between the per-connection TCP controllers and the
// round-robin arbiter that owns the shared memory/transmit path.
interface tcp_rr_arbiter_if #(
    parameter int CH_NUM = 4,
    parameter int IDW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
    logic [CH_NUM-1:0] req_i;
    logic [CH_NUM-1:0] en_mask_i;
    logic              block_i;
    logic              done_i;
    logic              repeat_i;
    logic              flush_i;
    logic [CH_NUM-1:0] grant_o;
    logic              grant_vld_o;
    logic [IDW-1:0]    grant_id_o;
    logic              timeout_o;

    // Controller side drives requests and sees grants.
    modport master (
        output req_i, en_mask_i, block_i, done_i, repeat_i, flush_i,
        input  grant_o, grant_vld_o, grant_id_o, timeout_o
    );

    // Arbiter side.
    modport slave (
        input  req_i, en_mask_i, block_i, done_i, repeat_i, flush_i,
        output grant_o, grant_vld_o, grant_id_o, timeout_o
    );
endinterface

// File: rtl/tcp_rr_arbiter.sv
// Rotating-priority arbiter for the shared TCP memory/MAC-transmit mux, with
// enable mask, bounded burst repeat and flush. Optional grant watchdog: TCP_ARB_WDOG_EN.
module tcp_rr_arbiter #(
    parameter int CH_NUM      = 4,
    parameter int IDW         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int MAX_REPEAT  = 3,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    tcp_rr_arbiter_if.slave  arb
);

    if (CH_NUM < 2 || CH_NUM > 32 || MAX_REPEAT < 1 || MAX_REPEAT > 15 || WDOG_CYCLES < 2)
    begin : g_param_chk
        $error("tcp_rr_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t            state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    id_q;
    logic [3:0]        rcnt_q;
    logic [CH_NUM-1:0] grant_q;
    logic              vld_q;

    logic [CH_NUM-1:0] eff;
    logic [IDW-1:0]    win_id;
    logic [IDW-1:0]    ptr_d;
    logic              rep_ok;

    // First set bit of e scanning upward from p with wrap-around.
    function automatic logic [IDW-1:0] rr_pick(input logic [CH_NUM-1:0] e,
                                               input logic [IDW-1:0]    p);
        logic [IDW-1:0] w;
        logic           found;
        int unsigned    c;
        w     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            c = (32'(p) + i) % CH_NUM;
            if (!found && e[c[IDW-1:0]]) begin
                w     = c[IDW-1:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign eff    = arb.req_i & arb.en_mask_i;
    assign win_id = rr_pick(eff, ptr_q);
    assign ptr_d  = (id_q == IDW'(CH_NUM - 1)) ? '0 : id_q + IDW'(1);
    assign rep_ok = arb.repeat_i && ((32'(rcnt_q) + 32'd1) < 32'(MAX_REPEAT)) && eff[id_q];

`ifdef TCP_ARB_WDOG_EN
    localparam int WDW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    logic [WDW-1:0] wdog_q;
    logic           timeout_q;
    assign arb.timeout_o = timeout_q;
`else
    assign arb.timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            rcnt_q    <= '0;
            grant_q   <= '0;
            vld_q     <= 1'b0;
`ifdef TCP_ARB_WDOG_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef TCP_ARB_WDOG_EN
            timeout_q <= 1'b0;
`endif
            if (arb.flush_i) begin
                state_q <= ST_IDLE;
                grant_q <= '0;
                vld_q   <= 1'b0;
                ptr_q   <= '0;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (eff != '0 && !arb.block_i) state_q <= ST_ARB;
                    end
                    ST_ARB: begin
                        // Requests may have vanished during the arbitration cycle.
                        if (eff == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_GRANT;
                            id_q    <= win_id;
                            grant_q <= {{(CH_NUM-1){1'b0}}, 1'b1} << win_id;
                            vld_q   <= 1'b1;
`ifdef TCP_ARB_WDOG_EN
                            wdog_q  <= '0;
`endif
                        end
                    end
                    ST_GRANT: begin
                        if (arb.done_i && rep_ok) begin
                            rcnt_q <= rcnt_q + 4'd1;
`ifdef TCP_ARB_WDOG_EN
                            wdog_q <= '0;
`endif
                        end else if (arb.done_i) begin
                            state_q <= ST_RELEASE;
                            grant_q <= '0;
                            vld_q   <= 1'b0;
                            rcnt_q  <= '0;
                            ptr_q   <= ptr_d;
`ifdef TCP_ARB_WDOG_EN
                        end else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
                            state_q   <= ST_RELEASE;
                            grant_q   <= '0;
                            vld_q     <= 1'b0;
                            rcnt_q    <= '0;
                            ptr_q     <= ptr_d;
                            timeout_q <= 1'b1;
                        end else begin
                            wdog_q <= wdog_q + WDW'(1);
`endif
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign arb.grant_o     = grant_q;
    assign arb.grant_vld_o = vld_q;
    assign arb.grant_id_o  = id_q;

endmodule
